// File: rtl/mul_div_unit_if.sv
// Command/result bundle between the execute-stage decoder and mul_div_unit.
// The decoder side (master) drives the command and operands; the unit
// (slave) returns busy, the combinational readback and the HI/LO registers.
interface mul_div_unit_if;
  logic [2:0]  mulCtrl;
  logic        mulEnable;
  logic        mulOutputSel;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        busy;
  logic [31:0] dataOut;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output mulCtrl, mulEnable, mulOutputSel, operandA, operandB,
    input  busy, dataOut, hi, lo
  );

  modport slave (
    input  mulCtrl, mulEnable, mulOutputSel, operandA, operandB,
    output busy, dataOut, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multiply/divide unit owning the architectural HI/LO registers.
// Long operations latch their operands and opcode on acceptance, hold busy
// for a fixed number of cycles, and write HI/LO on the edge busy falls.
// mtSetHI/mtSetLO write immediately and never raise busy.
module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic         clk,
  input logic         reset_n,
  mul_div_unit_if.slave bus
);
  // Opcode encoding shared with the instruction decoder.
  localparam logic [2:0] OP_DISABLED = 3'd0;
  localparam logic [2:0] OP_MULT     = 3'd1;
  localparam logic [2:0] OP_MULTU    = 3'd2;
  localparam logic [2:0] OP_DIV      = 3'd3;
  localparam logic [2:0] OP_DIVU     = 3'd4;
  localparam logic [2:0] OP_SETHI    = 3'd5;
  localparam logic [2:0] OP_SETLO    = 3'd6;
  localparam logic [2:0] OP_MSUB     = 3'd7;

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;

  logic        w_cmd_valid, w_is_mul, w_is_div, w_accept_long, w_done;
  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_abs_a, w_abs_b, w_div_b, w_uq, w_ur, w_sq, w_sr;
  logic [31:0] w_res_hi, w_res_lo;
  logic        w_res_we;

  assign w_cmd_valid   = bus.mulEnable && (bus.mulCtrl != OP_DISABLED);
  assign w_is_mul      = (bus.mulCtrl == OP_MULT) || (bus.mulCtrl == OP_MULTU) ||
                         (bus.mulCtrl == OP_MSUB);
  assign w_is_div      = (bus.mulCtrl == OP_DIV) || (bus.mulCtrl == OP_DIVU);
  assign w_accept_long = (r_state == ST_IDLE) && w_cmd_valid && (w_is_mul || w_is_div);
  assign w_done        = (r_state == ST_RUN) && (r_cnt == CW'(1));

  // Next-state and cycle counter: IDLE loads the counter on a long command,
  // RUN counts down and returns to IDLE on the edge the counter hits zero.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_long) begin
          w_state_next = ST_RUN;
          w_cnt_next   = w_is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        end
      end
      ST_RUN: begin
        w_cnt_next = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Arithmetic on the latched operands. Signed division runs on magnitudes,
  // so 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'b0, r_a} * {32'b0, r_b};
  assign w_abs_a  = (r_op == OP_DIV && r_a[31]) ? (32'd0 - r_a) : r_a;
  assign w_abs_b  = (r_op == OP_DIV && r_b[31]) ? (32'd0 - r_b) : r_b;
  assign w_div_b  = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;  // keep the divider defined
  assign w_uq     = w_abs_a / w_div_b;
  assign w_ur     = w_abs_a % w_div_b;
  assign w_sq     = (r_a[31] ^ r_b[31]) ? (32'd0 - w_uq) : w_uq;
  assign w_sr     = r_a[31] ? (32'd0 - w_ur) : w_ur;

  // Result selection for the completing operation; divide by zero leaves HI/LO alone.
  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    w_res_we = 1'b0;
    case (r_op)
      OP_MULT:  begin {w_res_hi, w_res_lo} = w_prod_s; w_res_we = 1'b1; end
      OP_MULTU: begin {w_res_hi, w_res_lo} = w_prod_u; w_res_we = 1'b1; end
      OP_MSUB:  begin {w_res_hi, w_res_lo} = {r_hi, r_lo} - w_prod_s; w_res_we = 1'b1; end
      OP_DIV:   begin w_res_lo = w_sq; w_res_hi = w_sr; w_res_we = (r_b != 32'd0); end
      OP_DIVU:  begin w_res_lo = w_uq; w_res_hi = w_ur; w_res_we = (r_b != 32'd0); end
      default:  begin w_res_we = 1'b0; end
    endcase
  end

  // State, operand latches and HI/LO; reset clears everything including any pending result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_DISABLED;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept_long) begin
        r_op <= bus.mulCtrl;
        r_a  <= bus.operandA;
        r_b  <= bus.operandB;
      end
      if (r_state == ST_IDLE && w_cmd_valid && bus.mulCtrl == OP_SETHI) r_hi <= bus.operandA;
      if (r_state == ST_IDLE && w_cmd_valid && bus.mulCtrl == OP_SETLO) r_lo <= bus.operandA;
      if (w_done && w_res_we) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign bus.busy    = (r_state == ST_RUN);
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.dataOut = bus.mulOutputSel ? r_hi : r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random commands
// checked against a plain-arithmetic HI/LO reference model.
module tb_mul_div_unit;
  localparam logic [2:0] OP_DISABLED = 3'd0;
  localparam logic [2:0] OP_MULT     = 3'd1;
  localparam logic [2:0] OP_MULTU    = 3'd2;
  localparam logic [2:0] OP_DIV      = 3'd3;
  localparam logic [2:0] OP_DIVU     = 3'd4;
  localparam logic [2:0] OP_SETHI    = 3'd5;
  localparam logic [2:0] OP_SETLO    = 3'd6;
  localparam logic [2:0] OP_MSUB     = 3'd7;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mul_div_unit_if bus();

  mul_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] hi_m, lo_m;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural effect of one accepted command on HI/LO
  // and the number of busy cycles it costs.
  task automatic model_op(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
    int sa, sb, q, r;
    longint p;
    longint unsigned up, acc;
    sa = a;
    sb = b;
    cycles = 0;
    case (ctrl)
      OP_MULT: begin
        p = longint'(sa) * longint'(sb);
        {hi_m, lo_m} = p;
        cycles = MUL_N;
      end
      OP_MULTU: begin
        up = longint'({32'b0, a}) * longint'({32'b0, b});
        {hi_m, lo_m} = up;
        cycles = MUL_N;
      end
      OP_MSUB: begin
        p = longint'(sa) * longint'(sb);
        acc = {hi_m, lo_m};
        acc = acc - longint'(p);
        {hi_m, lo_m} = acc;
        cycles = MUL_N;
      end
      OP_DIV: begin
        if (b != 0) begin
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = sa; r = 0;
          end else begin
            q = sa / sb; r = sa % sb;
          end
          lo_m = q;
          hi_m = r;
        end
        cycles = DIV_N;
      end
      OP_DIVU: begin
        if (b != 0) begin
          lo_m = a / b;
          hi_m = a % b;
        end
        cycles = DIV_N;
      end
      OP_SETHI: hi_m = a;
      OP_SETLO: lo_m = a;
      default: cycles = 0;
    endcase
  endtask

  // Issue one command, scramble the operands afterwards, measure busy length,
  // then compare HI/LO and both readback selections with the model.
  task automatic run_op(input string tag, input logic [2:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b);
    int cyc_exp;
    int cyc;
    model_op(ctrl, a, b, cyc_exp);
    @(negedge clk);
    bus.mulCtrl   = ctrl;
    bus.mulEnable = (ctrl != OP_DISABLED);
    bus.operandA  = a;
    bus.operandB  = b;
    @(negedge clk);
    bus.mulCtrl   = OP_DISABLED;
    bus.mulEnable = 1'b0;
    bus.operandA  = $urandom;
    bus.operandB  = $urandom;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    check_value({tag, ".busy_cycles"}, 64'(cyc), 64'(cyc_exp));
    check_value({tag, ".hi"}, 64'(bus.hi), 64'(hi_m));
    check_value({tag, ".lo"}, 64'(bus.lo), 64'(lo_m));
    bus.mulOutputSel = 1'b1;
    #1 check_value({tag, ".dataOut_hi"}, 64'(bus.dataOut), 64'(hi_m));
    bus.mulOutputSel = 1'b0;
    #1 check_value({tag, ".dataOut_lo"}, 64'(bus.dataOut), 64'(lo_m));
    $display("txn %-10s ctrl=%0d a=%08h b=%08h -> hi=%08h lo=%08h busy=%0d",
             tag, ctrl, a, b, bus.hi, bus.lo, cyc);
  endtask

  initial begin
    int cyc;
    logic [2:0]  rc;
    logic [31:0] ra, rb;
    int cyc_dummy;

    bus.mulCtrl      = OP_DISABLED;
    bus.mulEnable    = 1'b0;
    bus.mulOutputSel = 1'b0;
    bus.operandA     = '0;
    bus.operandB     = '0;
    reset_n          = 1'b0;
    hi_m = '0;
    lo_m = '0;
    repeat (2) @(negedge clk);
    check_value("reset.busy", 64'(bus.busy), 64'd0);
    check_value("reset.hi", 64'(bus.hi), 64'd0);
    check_value("reset.lo", 64'(bus.lo), 64'd0);
    reset_n = 1'b1;

    // Directed cases
    run_op("mult",     OP_MULT,  32'hFFFFFFFF, 32'd2);
    run_op("multu",    OP_MULTU, 32'hFFFFFFFF, 32'd2);
    run_op("div",      OP_DIV,   32'hFFFFFFF9, 32'd2);
    run_op("divu",     OP_DIVU,  32'd7,        32'd2);
    run_op("div_ovf",  OP_DIV,   32'h80000000, 32'hFFFFFFFF);
    run_op("sethi11",  OP_SETHI, 32'h11,       32'd0);
    run_op("setlo22",  OP_SETLO, 32'h22,       32'd0);
    run_op("div_zero", OP_DIV,   32'h1234,     32'd0);
    run_op("divu_zero",OP_DIVU,  32'h1234,     32'd0);
    run_op("sethi",    OP_SETHI, 32'h12345678, 32'd0);
    run_op("sethi0",   OP_SETHI, 32'd0,        32'd0);
    run_op("setlo0",   OP_SETLO, 32'd0,        32'd0);
    run_op("msub",     OP_MSUB,  32'd3,        32'd4);

    // Random commands
    for (int i = 0; i < 40; i++) begin
      rc = 3'($urandom_range(1, 7));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h80000000; rb = $urandom; end
        default: rb = $urandom;
      endcase
      run_op("rand", rc, ra, rb);
    end

    // Command presented while busy must be ignored
    model_op(OP_DIV, 32'd100, 32'd7, cyc_dummy);
    @(negedge clk);
    bus.mulCtrl = OP_DIV; bus.mulEnable = 1'b1; bus.operandA = 32'd100; bus.operandB = 32'd7;
    @(negedge clk);
    bus.mulCtrl = OP_DISABLED; bus.mulEnable = 1'b0;
    @(negedge clk);
    bus.mulCtrl = OP_SETLO; bus.mulEnable = 1'b1; bus.operandA = 32'h55;
    check_value("busy_cmd.busy_at_issue", 64'(bus.busy), 64'd1);
    if (bus.busy === 1'b1)
      $display("NOTE: mtSetLO presented while busy; stall logic should have held it");
    @(negedge clk);
    bus.mulCtrl = OP_DISABLED; bus.mulEnable = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    check_value("busy_cmd.busy_cycles", 64'(cyc), 64'(DIV_N - 2));
    check_value("busy_cmd.lo", 64'(bus.lo), 64'(lo_m));
    check_value("busy_cmd.hi", 64'(bus.hi), 64'(hi_m));
    $display("txn busy_cmd   ctrl=%0d a=%08h b=%08h -> hi=%08h lo=%08h", OP_DIV, 32'd100, 32'd7, bus.hi, bus.lo);

    // Reset in the third busy cycle of a multiply
    @(negedge clk);
    bus.mulCtrl = OP_MULT; bus.mulEnable = 1'b1; bus.operandA = 32'h1234567; bus.operandB = 32'h89AB;
    @(negedge clk);
    bus.mulCtrl = OP_DISABLED; bus.mulEnable = 1'b0;
    repeat (2) @(negedge clk);
    check_value("rst_mid.busy_before", 64'(bus.busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_value("rst_mid.busy", 64'(bus.busy), 64'd0);
    check_value("rst_mid.hi", 64'(bus.hi), 64'd0);
    check_value("rst_mid.lo", 64'(bus.lo), 64'd0);
    hi_m = '0;
    lo_m = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check_value("rst_mid.late_busy", 64'(bus.busy), 64'd0);
    check_value("rst_mid.late_hi", 64'(bus.hi), 64'd0);
    check_value("rst_mid.late_lo", 64'(bus.lo), 64'd0);
    $display("txn rst_mid    hi=%08h lo=%08h busy=%0d", bus.hi, bus.lo, bus.busy);

    // Unit still works after the reset
    run_op("post_rst", OP_MULTU, 32'h10000, 32'h10000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
